// File: rtl/regfile_wb_pkg.sv
// Shared types and widths for the regfile writeback arbiter.
// Imported by wb_prio_pick and regfile_wb_arbiter.
package regfile_wb_pkg;

  localparam int REG_AW       = 5;
  localparam int DATA_W       = 32;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    G0 = 1'b0,
    G1 = 1'b1
  } grant_t;

endpackage

// File: rtl/wb_prio_pick.sv
// Combinational winner select for the writeback arbiter.
// cwin is the conflict winner; ready never looks at its own valid.
module wb_prio_pick
  import regfile_wb_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic                    v0,
  input  logic                    v1,
  input  grant_t                  last_grant,
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
  output grant_t                  cwin,
  output logic                    rdy0,
  output logic                    rdy1
);

  localparam logic [STARVE_CNT_W-1:0] SMAX =
    STARVE_CNT_W'(STARVE_MAX);

  // who would win if both sources were valid
  always_comb begin
    cwin = G0;
    unique case (1'b1)
      (FIXED_PRIO != 0): cwin = (starve_cnt == SMAX) ? G0 : G1;
      default:           cwin = (last_grant == G0) ? G1 : G0;
    endcase
  end

  // a source is held off only when the other is valid and wins
  always_comb begin
    rdy0 = !(v1 && (cwin == G1));
    rdy1 = !(v0 && (cwin == G0));
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the single regfile write port.
// Optional WB_STATS_EN adds conflict / r0-drop counters.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wb0_valid,
  input  logic [REG_AW-1:0] wb0_wn,
  input  logic [DATA_W-1:0] wb0_d,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [REG_AW-1:0] wb1_wn,
  input  logic [DATA_W-1:0] wb1_d,
  output logic              wb1_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wn,
  output logic [DATA_W-1:0] rf_d,
  output logic              conflict
`ifdef WB_STATS_EN
  ,
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_r0_drops
`endif
);

  localparam logic [STARVE_CNT_W-1:0] SMAX =
    STARVE_CNT_W'(STARVE_MAX);

  grant_t                  last_grant;
  grant_t                  cwin;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    hs0;
  logic                    hs1;

  wb_prio_pick #(
    .FIXED_PRIO (FIXED_PRIO),
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .v0         (wb0_valid),
    .v1         (wb1_valid),
    .last_grant (last_grant),
    .starve_cnt (starve_cnt),
    .cwin       (cwin),
    .rdy0       (wb0_ready),
    .rdy1       (wb1_ready)
  );

  // handshakes and the hazard-unit stall hint
  always_comb begin
    conflict = wb0_valid && wb1_valid;
    hs0      = wb0_valid && wb0_ready;
    hs1      = wb1_valid && wb1_ready;
  end

  // registered write port; r0 writes are accepted but not issued
  always_ff @(posedge clk) begin
    if (clr) begin
      rf_we <= 1'b0;
      rf_wn <= '0;
      rf_d  <= '0;
    end else begin
      rf_we <= 1'b0;
      if (hs0) begin
        rf_we <= (wb0_wn != '0);
        if (wb0_wn != '0) begin
          rf_wn <= wb0_wn;
          rf_d  <= wb0_d;
        end
      end else if (hs1) begin
        rf_we <= (wb1_wn != '0);
        if (wb1_wn != '0) begin
          rf_wn <= wb1_wn;
          rf_d  <= wb1_d;
        end
      end
    end
  end

  // round-robin history, moves only on a completed handshake
  always_ff @(posedge clk) begin
    if (clr) begin
      last_grant <= G1;
    end else if (hs0) begin
      last_grant <= G0;
    end else if (hs1) begin
      last_grant <= G1;
    end
  end

  // count conflicts the ALU loses so it cannot starve forever
  always_ff @(posedge clk) begin
    if (clr || (FIXED_PRIO == 0)) begin
      starve_cnt <= '0;
    end else if (!wb0_valid || hs0) begin
      starve_cnt <= '0;
    end else if (conflict && hs1 && (starve_cnt != SMAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef WB_STATS_EN
  logic r0_drop;

  always_comb begin
    r0_drop = (hs0 && (wb0_wn == '0)) ||
              (hs1 && (wb1_wn == '0));
  end

  // saturating statistics counters
  always_ff @(posedge clk) begin
    if (clr) begin
      stat_conflicts <= '0;
      stat_r0_drops  <= '0;
    end else begin
      if (conflict && (stat_conflicts != 16'hFFFF))
        stat_conflicts <= stat_conflicts + 16'd1;
      if (r0_drop && (stat_r0_drops != 16'hFFFF))
        stat_r0_drops <= stat_r0_drops + 16'd1;
    end
  end
`endif

endmodule
